// File: rtl/rv64g_pkg.sv
// Shared RV64G definitions used by the branch resolve unit.
// Provides the address width, instruction size, the in-flight prediction
// entry and the resolver state encoding.
package rv64g_pkg;

  localparam int XLEN        = 64;
  localparam int INSTR_BYTES = 4;

  // One in-flight prediction: where fetch was and where the BTB sent it next.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
  } pred_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } res_state_e;

endpackage

// File: rtl/tmd_branch_resolve_unit_if.sv
// Handshake bundle between fetch/execute (master) and the branch resolve
// unit (slave).
//   pred_*  : fetch pushes predictions, unit answers pred_ready_o
//   res_*   : execute resolves the oldest prediction, unit answers res_ready_o
//   upd_*   : BTB write port driven by the unit
//   flush_o / redirect_pc_o : pipeline clear and restart PC
interface tmd_branch_resolve_unit_if;
  import rv64g_pkg::*;

  logic            pred_valid_i;
  logic [XLEN-1:0] pred_pc_i;
  logic [XLEN-1:0] pred_next_pc_i;
  logic            pred_ready_o;
  logic            res_valid_i;
  logic            res_is_jump_i;
  logic [XLEN-1:0] res_target_i;
  logic            res_ready_o;
  logic            upd_valid_o;
  logic [XLEN-1:0] upd_curr_addr_o;
  logic [XLEN-1:0] upd_next_addr_o;
  logic            upd_is_jump_o;
  logic            flush_o;
  logic [XLEN-1:0] redirect_pc_o;

  modport master (
    output pred_valid_i, pred_pc_i, pred_next_pc_i,
    output res_valid_i, res_is_jump_i, res_target_i,
    input  pred_ready_o, res_ready_o,
    input  upd_valid_o, upd_curr_addr_o, upd_next_addr_o, upd_is_jump_o,
    input  flush_o, redirect_pc_o
  );

  modport slave (
    input  pred_valid_i, pred_pc_i, pred_next_pc_i,
    input  res_valid_i, res_is_jump_i, res_target_i,
    output pred_ready_o, res_ready_o,
    output upd_valid_o, upd_curr_addr_o, upd_next_addr_o, upd_is_jump_o,
    output flush_o, redirect_pc_o
  );

endinterface

// File: rtl/tmd_pred_fifo.sv
// In-order queue of in-flight predictions.
//   clk_i/arst_ni : clock, async active-low reset
//   push_i/data_i : enqueue (ignored when full or clearing)
//   pop_i         : dequeue head (ignored when empty or clearing)
//   clear_i       : drop every entry
//   head_o        : oldest entry, valid while !empty_o
//   full_o/empty_o: occupancy flags from the registered count
module tmd_pred_fifo #(
  parameter int  DEPTH   = 8,
  parameter type entry_t = logic
) (
  input  logic   clk_i,
  input  logic   arst_ni,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  input  logic   clear_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  entry_t        mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[head_q];

  assign push_ok = push_i & ~full_o & ~clear_i;
  assign pop_ok  = pop_i & ~empty_o & ~clear_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally on overflow.
      if (push_ok) tail_d = tail_q + PTR_ONE;
      if (pop_ok)  head_d = head_q + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[tail_q] <= data_i;
  end

endmodule

// File: rtl/tmd_branch_resolve_unit.sv
// Branch resolve unit: tracks fetch predictions in order, checks each
// execute resolution against its prediction, writes the BTB and raises a
// one-cycle flush with a redirect PC on a mispredict.
//   clk_i   : clock, rising edge
//   arst_ni : async active-low reset
//   bus     : prediction / resolution / BTB update / flush signals
module tmd_branch_resolve_unit
  import rv64g_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  tmd_branch_resolve_unit_if.slave  bus
);

  res_state_e      state_q, state_d;
  pred_entry_t     head, push_entry;
  logic            full, empty;
  logic            pred_ready, res_ready;
  logic            push, pop, mispredict;
  logic [XLEN-1:0] actual;

  logic            upd_valid_q, upd_valid_d;
  logic [XLEN-1:0] upd_curr_q, upd_curr_d;
  logic [XLEN-1:0] upd_next_q, upd_next_d;
  logic            upd_jump_q, upd_jump_d;
  logic            flush_q, flush_d;
  logic [XLEN-1:0] redirect_q, redirect_d;

  assign push_entry = '{pc: bus.pred_pc_i, next_pc: bus.pred_next_pc_i};

  tmd_pred_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (pred_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .clear_i (mispredict),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    // Readies also drop while reset is held, not only after the flops clear.
    pred_ready  = arst_ni & (state_q == RUN) & ~full;
    res_ready   = arst_ni & (state_q == RUN) & ~empty;
    pop         = bus.res_valid_i & res_ready;
    actual      = bus.res_is_jump_i ? bus.res_target_i
                                    : head.pc + XLEN'(INSTR_BYTES);
    // Full-width compare: a misaligned predicted target counts as wrong.
    mispredict  = pop & (actual != head.next_pc);
    // Younger pushes are wrong-path once a mispredict is seen.
    push        = bus.pred_valid_i & pred_ready & ~mispredict;

    state_d     = RUN;
    if (state_q == RUN && mispredict) state_d = FLUSH;

    upd_valid_d = pop & (bus.res_is_jump_i | mispredict);
    upd_curr_d  = upd_curr_q;
    upd_next_d  = upd_next_q;
    upd_jump_d  = upd_jump_q;
    if (pop) begin
      upd_curr_d = head.pc;
      upd_next_d = actual;
      upd_jump_d = bus.res_is_jump_i;
    end
    flush_d     = mispredict;
    redirect_d  = mispredict ? actual : redirect_q;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q     <= RUN;
      upd_valid_q <= 1'b0;
      upd_curr_q  <= '0;
      upd_next_q  <= '0;
      upd_jump_q  <= 1'b0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
    end else begin
      state_q     <= state_d;
      upd_valid_q <= upd_valid_d;
      upd_curr_q  <= upd_curr_d;
      upd_next_q  <= upd_next_d;
      upd_jump_q  <= upd_jump_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
    end
  end

  assign bus.pred_ready_o    = pred_ready;
  assign bus.res_ready_o     = res_ready;
  assign bus.upd_valid_o     = upd_valid_q;
  assign bus.upd_curr_addr_o = upd_curr_q;
  assign bus.upd_next_addr_o = upd_next_q;
  assign bus.upd_is_jump_o   = upd_jump_q;
  assign bus.flush_o         = flush_q;
  assign bus.redirect_pc_o   = redirect_q;

endmodule

// File: tb/tb_tmd_branch_resolve_unit.sv
// Directed bench for tmd_branch_resolve_unit with a prediction-queue model
// and a scoreboard of expected BTB update / flush results.
module tb_tmd_branch_resolve_unit;
  import rv64g_pkg::*;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  tmd_branch_resolve_unit_if bus();

  tmd_branch_resolve_unit #(.DEPTH(8)) dut (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .bus     (bus)
  );

  typedef struct {
    logic        upd_valid;
    logic [63:0] curr;
    logic [63:0] nxt;
    logic        jump;
    logic        flush;
    logic [63:0] redirect;
  } exp_t;

  exp_t        exp_q[$];
  pred_entry_t mq[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_redirect = '0;
  logic        mis;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pred(input logic [63:0] pc, input logic [63:0] nxt);
    logic rdy;
    rdy = (mq.size() < 8);
    chk("pred_ready", bus.pred_ready_o, rdy);
    bus.pred_valid_i   = 1'b1;
    bus.pred_pc_i      = pc;
    bus.pred_next_pc_i = nxt;
    tick();
    bus.pred_valid_i = 1'b0;
    if (rdy) mq.push_back('{pc: pc, next_pc: nxt});
  endtask

  // Resolve the oldest entry, optionally pushing a new prediction in the same cycle.
  task automatic resolve(input logic jump, input logic [63:0] target,
                         input logic do_push, input logic [63:0] ppc,
                         input logic [63:0] pnext, output logic mis_o);
    pred_entry_t h;
    exp_t        e;
    logic [63:0] act;
    logic        prdy;
    chk("res_ready", bus.res_ready_o, mq.size() != 0);
    prdy = (mq.size() < 8);
    if (do_push) chk("pred_ready_same_cycle", bus.pred_ready_o, prdy);
    h   = mq.pop_front();
    act = jump ? target : h.pc + 64'd4;
    mis_o = (act != h.next_pc);
    e.upd_valid = jump | mis_o;
    e.curr      = h.pc;
    e.nxt       = act;
    e.jump      = jump;
    e.flush     = mis_o;
    e.redirect  = mis_o ? act : last_redirect;
    last_redirect = e.redirect;
    exp_q.push_back(e);
    bus.res_valid_i    = 1'b1;
    bus.res_is_jump_i  = jump;
    bus.res_target_i   = target;
    bus.pred_valid_i   = do_push;
    bus.pred_pc_i      = ppc;
    bus.pred_next_pc_i = pnext;
    tick();
    bus.res_valid_i  = 1'b0;
    bus.pred_valid_i = 1'b0;
    if (mis_o) mq.delete();
    else if (do_push && prdy) mq.push_back('{pc: ppc, next_pc: pnext});
    e = exp_q.pop_front();
    chk("upd_valid", bus.upd_valid_o, e.upd_valid);
    chk("flush", bus.flush_o, e.flush);
    chk("redirect_pc", bus.redirect_pc_o, e.redirect);
    if (e.upd_valid) begin
      chk("upd_curr", bus.upd_curr_addr_o, e.curr);
      chk("upd_next", bus.upd_next_addr_o, e.nxt);
      chk("upd_jump", bus.upd_is_jump_o, e.jump);
    end
  endtask

  // The cycle after a mispredict: FLUSH state, then back to RUN with an empty queue.
  task automatic flush_cycle();
    chk("flush_pred_ready", bus.pred_ready_o, 1'b0);
    chk("flush_res_ready", bus.res_ready_o, 1'b0);
    tick();
    chk("post_flush_pulse", bus.flush_o, 1'b0);
    chk("post_flush_upd", bus.upd_valid_o, 1'b0);
    chk("post_flush_pred_ready", bus.pred_ready_o, 1'b1);
    chk("post_flush_res_ready", bus.res_ready_o, 1'b0);
    chk("redirect_hold", bus.redirect_pc_o, last_redirect);
  endtask

  initial begin
    bus.pred_valid_i   = 1'b0;
    bus.pred_pc_i      = '0;
    bus.pred_next_pc_i = '0;
    bus.res_valid_i    = 1'b0;
    bus.res_is_jump_i  = 1'b0;
    bus.res_target_i   = '0;

    // Reset state
    #12;
    chk("rst_pred_ready", bus.pred_ready_o, 1'b0);
    chk("rst_res_ready", bus.res_ready_o, 1'b0);
    chk("rst_upd_valid", bus.upd_valid_o, 1'b0);
    chk("rst_upd_curr", bus.upd_curr_addr_o, 64'd0);
    chk("rst_upd_next", bus.upd_next_addr_o, 64'd0);
    chk("rst_upd_jump", bus.upd_is_jump_o, 1'b0);
    chk("rst_flush", bus.flush_o, 1'b0);
    chk("rst_redirect", bus.redirect_pc_o, 64'd0);
    arst_n = 1'b1;
    tick();

    // Correct not-taken: nothing written
    push_pred(64'h1000, 64'h1004);
    resolve(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, mis);
    chk("nt_empty_res_ready", bus.res_ready_o, 1'b0);
    chk("nt_pred_ready", bus.pred_ready_o, 1'b1);

    // Taken branch predicted not-taken
    push_pred(64'h2000, 64'h2004);
    resolve(1'b1, 64'h3000, 1'b0, 64'h0, 64'h0, mis);
    flush_cycle();

    // Predicted taken, actually not taken: younger entries discarded
    push_pred(64'h4000, 64'h5000);
    push_pred(64'h4100, 64'h4104);
    push_pred(64'h4200, 64'h4204);
    resolve(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, mis);
    flush_cycle();

    // Push and correct pop together: count unchanged
    push_pred(64'h6000, 64'h6004);
    resolve(1'b1, 64'h6004, 1'b1, 64'h6100, 64'h6104, mis);
    chk("pushpop_res_ready", bus.res_ready_o, 1'b1);
    resolve(1'b1, 64'h6104, 1'b0, 64'h0, 64'h0, mis);
    chk("pushpop_drained", bus.res_ready_o, 1'b0);

    // Fill to DEPTH; pop+push at full refuses the push
    for (int i = 0; i < 8; i++)
      push_pred(64'h8000 + 64'(i) * 64'h10, 64'h8004 + 64'(i) * 64'h10);
    chk("full_pred_ready", bus.pred_ready_o, 1'b0);
    resolve(1'b0, 64'h0, 1'b1, 64'h9000, 64'h9004, mis);
    chk("after_full_pred_ready", bus.pred_ready_o, 1'b1);
    chk("after_full_res_ready", bus.res_ready_o, 1'b1);
    for (int i = 1; i < 8; i++)
      resolve(1'b1, 64'h8004 + 64'(i) * 64'h10, 1'b0, 64'h0, 64'h0, mis);
    chk("drain_res_ready", bus.res_ready_o, 1'b0);

    // PC wrap at top of address space
    push_pred(64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    resolve(1'b0, 64'h0, 1'b0, 64'h0, 64'h0, mis);
    chk("wrap_no_mispredict", mis, 1'b0);

    // Reset during the FLUSH cycle
    push_pred(64'hA000, 64'hA004);
    resolve(1'b1, 64'hB000, 1'b0, 64'h0, 64'h0, mis);
    arst_n = 1'b0;
    #1;
    chk("midrst_flush", bus.flush_o, 1'b0);
    chk("midrst_upd_valid", bus.upd_valid_o, 1'b0);
    chk("midrst_pred_ready", bus.pred_ready_o, 1'b0);
    chk("midrst_res_ready", bus.res_ready_o, 1'b0);
    chk("midrst_redirect", bus.redirect_pc_o, 64'd0);
    #2;
    arst_n = 1'b1;
    mq.delete();
    last_redirect = '0;
    #1;
    chk("rel_pred_ready", bus.pred_ready_o, 1'b1);
    chk("rel_res_ready", bus.res_ready_o, 1'b0);
    tick();
    chk("rel_flush", bus.flush_o, 1'b0);
    chk("rel_upd_valid", bus.upd_valid_o, 1'b0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
